updn_mod_counter: RTL
=====================

Name: updn_mod_counter

Overview:
Parametrised up/down counter with synchronous load, count enable and a runtime-programmable modulus. It generalises the team's fixed 4-bit loadable up-counter to any width and to arbitrary wrap points, and adds a terminal-count pulse. It is used as a general timer, divider and address-sequencer primitive in datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits; legal range 2..32.
RST_VAL, 0, value of dout after reset; must be <= 2^WIDTH-1.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
en  in  1  count enable; the counter holds when low
up  in  1  direction: 1 counts up, 0 counts down
load  in  1  synchronous load strobe; active high
load_val  in  WIDTH  value captured when load=1
mod_max  in  WIDTH  terminal (highest) count; the counter cycles through 0..mod_max
dout  out  WIDTH  current count, registered
tc  out  1  registered one-cycle pulse, high in the cycle after a wrap
zero  out  1  combinational, equals (dout == 0)

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst=0 forces dout=RST_VAL and tc=0 immediately, regardless of clk. Release is synchronised by the integrator. The first count occurs on the first rising edge with rst=1.
- All updates are on the rising edge of clk. Next-state priority, evaluated per edge:
  - load=1: dout <= load_val; tc <= 0. Load overrides en and up.
  - else en=0: dout holds; tc <= 0.
  - else en=1, up=1:
    - dout >= mod_max: dout <= 0; tc <= 1.
    - otherwise: dout <= dout+1; tc <= 0.
  - else en=1, up=0:
    - dout == 0: dout <= mod_max; tc <= 1.
    - otherwise: dout <= dout-1; tc <= 0.
- Latency: dout reflects an operation one cycle after the edge that samples it. tc is high for exactly the cycle following the wrap edge.
- Arithmetic is unsigned and modulo 2^WIDTH internally. The >= comparison guarantees that an out-of-range value (loaded or left after mod_max shrinks) returns to 0 on the next up-count instead of running past mod_max.
- Counting down from an out-of-range value decrements normally until it reaches 0, then wraps to mod_max.
- mod_max=0:
  - up-count holds at 0 with tc=1 on every enabled cycle.
  - down-count behaves identically.
- mod_max=2^WIDTH-1 gives natural binary wrap, matching the legacy counter when WIDTH=4 and up=1.
- mod_max and up may change on any cycle. The new value takes effect on the next edge; no pipeline state is kept.
- Reset asserted mid-count discards the count and any pending tc immediately.

Optional Feature:
Macro: UPDN_MOD_COUNTER_OVF_EN.
- Defined:
  - Adds input ovf_clr (1 bit) and output ovf (1 bit, registered).
  - ovf is set on any edge where tc is being set to 1.
  - ovf is cleared when ovf_clr=1. If set and clear coincide, set wins.
  - ovf resets to 0 under rst.
- Not defined:
  - Neither port exists.
  - No extra flops are inferred.
  - All other behaviour is identical.

Test Plan:
1. Reset/async: WIDTH=8, RST_VAL=5. Assert rst=0 between clock edges -> dout=5, tc=0 without a clock edge. Release, en=0 for 3 cycles -> dout stays 5.
2. Up wrap: mod_max=9, up=1, en=1 from 0 -> dout 0,1,...,9,0. tc high only in the cycle dout first shows 0 after 9. Period is 10 cycles.
3. Down wrap: mod_max=9, up=0 from 2 -> dout 1,0,9,8. tc high only in the cycle dout shows 9.
4. Load priority: load=1, load_val=200, en=1, up=1 with mod_max=9 -> dout=200, tc=0. Next edge with load=0 -> dout=0, tc=1.
5. Boundaries: mod_max=0, en=1 -> dout=0 and tc=1 every cycle for both directions. mod_max=255, up=1 from 254 -> 255 then 0 with tc=1.
6. OVF (macro defined): run 2 until wrap -> ovf=1 and stays 1. Assert ovf_clr in the same cycle as a wrap -> ovf remains 1. Assert ovf_clr alone -> ovf=0 next cycle.

Source files
------------

// File: rtl/updn_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | updn_mod_counter: up/down counter with sync load, enable, runtime modulus  |
// | and a registered wrap pulse. Optional ovf flag: UPDN_MOD_COUNTER_OVF_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module updn_mod_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_max,
`ifdef UPDN_MOD_COUNTER_OVF_EN
   input  logic             ovf_clr,
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] dout,
   output logic             tc,
   output logic             zero
);

   logic [WIDTH-1:0] dout_q, dout_d;
   logic             tc_q, tc_d;

   always_comb begin
      dout_d = dout_q;
      tc_d   = 1'b0;
      if (load) begin
         dout_d = load_val;
      end else if (en) begin
         if (up) begin
            // >= rather than == pulls out-of-range values back to 0
            if (dout_q >= mod_max) begin
               dout_d = '0;
               tc_d   = 1'b1;
            end else begin
               dout_d = dout_q + 1'b1;
            end
         end else begin
            if (dout_q == '0) begin
               dout_d = mod_max;
               tc_d   = 1'b1;
            end else begin
               dout_d = dout_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q <= RST_VAL;
         tc_q   <= 1'b0;
      end else begin
         dout_q <= dout_d;
         tc_q   <= tc_d;
      end
   end

`ifdef UPDN_MOD_COUNTER_OVF_EN
   logic ovf_q, ovf_d;

   // Set has priority over a coincident clear
   always_comb begin
      ovf_d = ovf_q;
      if (tc_d) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign dout = dout_q;
   assign tc   = tc_q;
   assign zero = (dout_q == '0);

endmodule
`default_nettype wire
